pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch address and arbitrates halts,
// redirects (branch/jump), stalls and sequential increments.
module pc_sequencer #(
   parameter int              PC_W     = 5,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            jump,
   input  logic [PC_W-1:0] jump_target,
   input  logic            halt_req,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic            if_valid,
   output logic            flush,
   output logic            wrap,
   output logic            halted,
   output logic [7:0]      stall_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STALL,
      FLUSH,
      HALT
   } state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [PC_W-1:0] pc_reg;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] pc_inc;
   logic            wrap_reg;
   logic            wrap_next;
   logic            flush_reg;
   logic            flush_next;
   logic [7:0]      stall_cnt_reg;
   logic [7:0]      stall_cnt_next;

   assign pc_inc = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_PC;
         wrap_reg      <= 1'b0;
         flush_reg     <= 1'b0;
         stall_cnt_reg <= 8'd0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         wrap_reg      <= wrap_next;
         flush_reg     <= flush_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   // Priority: halt_req > branch_taken > jump > stall > increment.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      wrap_next  = 1'b0;
      case (state_reg)
         IDLE: state_next = RUN;
         RUN, STALL, FLUSH: begin
            if (halt_req) begin
               state_next = HALT;
            end else if (branch_taken) begin
               pc_next    = branch_target;
               state_next = FLUSH;
            end else if (jump) begin
               pc_next    = jump_target;
               state_next = FLUSH;
            end else if (state_reg == FLUSH) begin
               // Target was loaded on entry; the first valid fetch is there.
               state_next = RUN;
            end else if (stall) begin
               state_next = STALL;
            end else begin
               pc_next    = pc_inc;
               wrap_next  = &pc_reg;
               state_next = RUN;
            end
         end
         HALT: begin
            if (resume && !halt_req) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      flush_next     = (state_next == FLUSH);
      stall_cnt_next = stall_cnt_reg;
      if (state_reg == STALL && stall_cnt_reg != 8'hFF) begin
         stall_cnt_next = stall_cnt_reg + 8'd1;
      end
   end

   assign pc        = pc_reg;
   assign if_valid  = (state_reg == RUN) || (state_reg == STALL);
   assign flush     = flush_reg;
   assign wrap      = wrap_reg;
   assign halted    = (state_reg == HALT);
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus checked
// against a mode-level reference model of the sequencing rules.
module tb_pc_sequencer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_STALL = 2;
   localparam int M_FLUSH = 3;
   localparam int M_HALT  = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       stall = 1'b0;
   logic       branch_taken = 1'b0;
   logic [4:0] branch_target = '0;
   logic       jump = 1'b0;
   logic [4:0] jump_target = '0;
   logic       halt_req = 1'b0;
   logic       resume = 1'b0;
   logic [4:0] pc;
   logic       if_valid;
   logic       flush;
   logic       wrap;
   logic       halted;
   logic [7:0] stall_cnt;

   int         vectors = 0;
   int         miscompares = 0;

   int         m_mode = M_IDLE;
   logic [4:0] m_pc = '0;
   logic       m_wrap = 1'b0;
   logic [7:0] m_cnt = '0;

   pc_sequencer #(.PC_W(5), .RESET_PC(5'd0)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target),
      .halt_req(halt_req), .resume(resume),
      .pc(pc), .if_valid(if_valid), .flush(flush), .wrap(wrap),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = M_IDLE;
      m_pc   = 5'd0;
      m_wrap = 1'b0;
      m_cnt  = 8'd0;
   endtask

   task automatic model_step(input logic s, input logic br, input logic [4:0] bt,
                             input logic j, input logic [4:0] jt,
                             input logic hr, input logic res);
      m_wrap = 1'b0;
      if (m_mode == M_STALL && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      case (m_mode)
         M_IDLE: m_mode = M_RUN;
         M_HALT: if (res && !hr) m_mode = M_RUN;
         default: begin
            if (hr) m_mode = M_HALT;
            else if (br || j) begin
               m_pc   = br ? bt : jt;
               m_mode = M_FLUSH;
            end else if (m_mode == M_FLUSH) m_mode = M_RUN;
            else if (s) m_mode = M_STALL;
            else begin
               m_wrap = (m_pc == 5'd31);
               m_pc   = m_pc + 5'd1;
               m_mode = M_RUN;
            end
         end
      endcase
   endtask

   task automatic tick(input logic s, input logic br, input logic [4:0] bt,
                       input logic j, input logic [4:0] jt,
                       input logic hr, input logic res);
      stall = s; branch_taken = br; branch_target = bt;
      jump = j; jump_target = jt; halt_req = hr; resume = res;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step(s, br, bt, j, jt, hr, res);
      #1;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   // Leaves the DUT in its IDLE cycle just after reset release.
   task automatic do_reset();
      reset_n = 1'b0;
      idle();
      idle();
      reset_n = 1'b1;
   endtask

   task automatic run_to(input int target);
      do_reset();
      idle();
      repeat (target) idle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      idle();
      vectors++;
      if ({pc, if_valid, flush, wrap, halted, stall_cnt} !== {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL reset_state: got pc=%0d v=%0b f=%0b w=%0b h=%0b sc=%0d, want all zero",
                  pc, if_valid, flush, wrap, halted, stall_cnt);
      end
      reset_n = 1'b1;
      repeat (6) idle();
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({pc, if_valid} !== {5'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset: got pc=%0d if_valid=%0b, want pc=0 if_valid=0", pc, if_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_run_wrap();
      do_reset();
      vectors++;
      if ({pc, if_valid} !== {5'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL idle_cycle: got pc=%0d if_valid=%0b, want pc=0 if_valid=0", pc, if_valid);
      end
      for (int i = 0; i < 32; i++) begin
         idle();
         vectors++;
         if ({pc, if_valid, wrap} !== {i[4:0], 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL run_seq: got pc=%0d v=%0b w=%0b, want pc=%0d v=1 w=0", pc, if_valid, wrap, i);
         end
      end
      idle();
      vectors++;
      if ({pc, wrap} !== {5'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL wrap_pulse: got pc=%0d wrap=%0b, want pc=0 wrap=1", pc, wrap);
      end
      idle();
      vectors++;
      if ({pc, wrap} !== {5'd1, 1'b0}) begin
         miscompares++;
         $display("FAIL wrap_end: got pc=%0d wrap=%0b, want pc=1 wrap=0", pc, wrap);
      end
      $display("test_run_wrap done");
   endtask

   task automatic test_stall();
      run_to(7);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         vectors++;
         if ({pc, if_valid} !== {5'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_hold: got pc=%0d v=%0b, want pc=7 v=1", pc, if_valid);
         end
      end
      idle();
      vectors++;
      if ({pc, stall_cnt} !== {5'd8, 8'd3}) begin
         miscompares++;
         $display("FAIL stall_release: got pc=%0d sc=%0d, want pc=8 sc=3", pc, stall_cnt);
      end
      run_to(2);
      repeat (260) tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle();
      vectors++;
      if ({pc, stall_cnt} !== {5'd3, 8'd255}) begin
         miscompares++;
         $display("FAIL stall_saturate: got pc=%0d sc=%0d, want pc=3 sc=255", pc, stall_cnt);
      end
      $display("test_stall done");
   endtask

   task automatic test_branch();
      run_to(4);
      tick(1'b0, 1'b1, 5'd20, 1'b1, 5'd9, 1'b0, 1'b0);
      vectors++;
      if ({pc, flush, if_valid} !== {5'd20, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL branch_prio: got pc=%0d f=%0b v=%0b, want pc=20 f=1 v=0", pc, flush, if_valid);
      end
      idle();
      vectors++;
      if ({pc, flush, if_valid} !== {5'd20, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL branch_fetch: got pc=%0d f=%0b v=%0b, want pc=20 f=0 v=1", pc, flush, if_valid);
      end
      idle();
      vectors++;
      if (pc !== 5'd21) begin
         miscompares++;
         $display("FAIL branch_next: got pc=%0d, want 21", pc);
      end
      run_to(20);
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
      vectors++;
      if ({pc, wrap, flush} !== {5'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL jump_to_zero: got pc=%0d w=%0b f=%0b, want pc=0 w=0 f=1", pc, wrap, flush);
      end
      $display("test_branch done");
   endtask

   task automatic test_flush_redirect();
      run_to(5);
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0);
      vectors++;
      if ({pc, flush} !== {5'd12, 1'b1}) begin
         miscompares++;
         $display("FAIL flush1: got pc=%0d f=%0b, want pc=12 f=1", pc, flush);
      end
      tick(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
      vectors++;
      if ({pc, flush, if_valid} !== {5'd3, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL flush2: got pc=%0d f=%0b v=%0b, want pc=3 f=1 v=0", pc, flush, if_valid);
      end
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if ({pc, flush, if_valid} !== {5'd3, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL flush_exit: got pc=%0d f=%0b v=%0b, want pc=3 f=0 v=1", pc, flush, if_valid);
      end
      idle();
      vectors++;
      if (pc !== 5'd4) begin
         miscompares++;
         $display("FAIL flush_stall_ignored: got pc=%0d, want 4", pc);
      end
      $display("test_flush_redirect done");
   endtask

   task automatic test_halt();
      run_to(10);
      tick(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
      vectors++;
      if ({pc, halted, if_valid} !== {5'd10, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_enter: got pc=%0d h=%0b v=%0b, want pc=10 h=1 v=0", pc, halted, if_valid);
      end
      tick(1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
      vectors++;
      if ({pc, halted, flush} !== {5'd10, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL halt_branch_ignored: got pc=%0d h=%0b f=%0b, want pc=10 h=1 f=0", pc, halted, flush);
      end
      tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      vectors++;
      if ({pc, halted} !== {5'd10, 1'b1}) begin
         miscompares++;
         $display("FAIL halt_both: got pc=%0d h=%0b, want pc=10 h=1", pc, halted);
      end
      tick(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      vectors++;
      if ({pc, halted, if_valid} !== {5'd10, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL resume: got pc=%0d h=%0b v=%0b, want pc=10 h=0 v=1", pc, halted, if_valid);
      end
      idle();
      vectors++;
      if (pc !== 5'd11) begin
         miscompares++;
         $display("FAIL resume_next: got pc=%0d, want 11", pc);
      end
      $display("test_halt done");
   endtask

   task automatic test_reset_mid_flush();
      run_to(6);
      tick(1'b0, 1'b1, 5'd25, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({pc, flush} !== {5'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_mid_flush: got pc=%0d f=%0b, want pc=0 f=0", pc, flush);
      end
      idle();
      reset_n = 1'b1;
      vectors++;
      if ({pc, flush, if_valid} !== {5'd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL post_reset_idle: got pc=%0d f=%0b v=%0b, want 0 0 0", pc, flush, if_valid);
      end
      idle();
      vectors++;
      if ({pc, flush, if_valid} !== {5'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL post_reset_run: got pc=%0d f=%0b v=%0b, want 0 0 1", pc, flush, if_valid);
      end
      idle();
      vectors++;
      if (pc !== 5'd1) begin
         miscompares++;
         $display("FAIL post_reset_next: got pc=%0d, want 1", pc);
      end
      $display("test_reset_mid_flush done");
   endtask

   task automatic test_random();
      logic exp_valid;
      do_reset();
      model_reset();
      for (int i = 0; i < 800; i++) begin
         reset_n = ($urandom_range(99) != 0);
         tick($urandom_range(99) < 30, $urandom_range(99) < 8, 5'($urandom_range(31)),
              $urandom_range(99) < 8, 5'($urandom_range(31)),
              $urandom_range(99) < 5, $urandom_range(99) < 30);
         exp_valid = (m_mode == M_RUN) || (m_mode == M_STALL);
         vectors++;
         if ({pc, if_valid, flush, wrap, halted, stall_cnt} !==
             {m_pc, exp_valid, m_mode == M_FLUSH, m_wrap, m_mode == M_HALT, m_cnt}) begin
            miscompares++;
            $display("FAIL random[%0d]: got pc=%0d v=%0b f=%0b w=%0b h=%0b sc=%0d, want pc=%0d v=%0b f=%0b w=%0b h=%0b sc=%0d",
                     i, pc, if_valid, flush, wrap, halted, stall_cnt,
                     m_pc, exp_valid, m_mode == M_FLUSH, m_wrap, m_mode == M_HALT, m_cnt);
         end else begin
            $display("rnd %0d pc=%0d v=%0b f=%0b w=%0b h=%0b sc=%0d",
                     i, pc, if_valid, flush, wrap, halted, stall_cnt);
         end
      end
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_run_wrap();
      test_stall();
      test_branch();
      test_flush_redirect();
      test_halt();
      test_reset_mid_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
